tz_rr_scheduler: RTL and testbench

- Shares one trailing-zero counting datapath between N_REQ requesters using round-robin arbitration with valid/ready handshakes.
- Each accepted word is counted and returned, tagged with its requester ID, through a single registered response stage.
- Sits between multiple producer stages and one downstream consumer of trailing-zero results.

---
 rtl/tz_rr_scheduler.sv | 166 ++++++++++++++++
 tb/tb_tz_rr_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tz_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tz_rr_scheduler
//
// Purpose:
//   Shares one trailing-zero counting datapath between N_REQ requesters.
//   A round-robin arbiter selects one requester per cycle. The selected word,
//   its requester index and its trailing-zero count are captured in a single
//   registered response stage for one downstream consumer.
//
// Parameters:
//   DATA_WIDTH  width of each request word
//   N_REQ       number of requesters (>= 2)
//   ID_W        requester tag width, derived from N_REQ (leave at default)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   req_valid   [N_REQ]             requester i presents a word
//   req_data    [N_REQ*DATA_WIDTH]  word of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   [N_REQ]             one-hot (or zero) accept strobe
//   resp_valid                      response register holds a result
//   resp_ready                      consumer takes the response this cycle
//   resp_id     [ID_W]              index of the requester that produced it
//   resp_data   [DATA_WIDTH]        echo of the accepted word
//   resp_count  [$clog2(DATA_WIDTH)+1]  trailing-zero count of resp_data
//   served_cnt  [16]                responses handed off, wraps at 2^16
//
// Handshake semantics (both sides):
//   A transfer happens in any cycle where valid and ready are both high at
//   the rising edge. On the request side, req_ready[i] is only raised for the
//   requester the arbiter picked, and only when the response register is free
//   or is being emptied in the same cycle. On the response side, resp_valid
//   stays high and resp_id/resp_data/resp_count stay stable until
//   resp_ready is seen; a producer may drop req_valid at any time before it
//   is granted and is then simply not considered.
// ---------------------------------------------------------------------------
module tz_rr_scheduler #(
    parameter int DATA_WIDTH = 4,
    parameter int N_REQ      = 4,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [$clog2(DATA_WIDTH):0]   resp_count,
    output logic [15:0]                   served_cnt
);

    localparam int          CNT_W   = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned N_REQ_U = N_REQ;
    localparam int unsigned DW_U    = DATA_WIDTH;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // (base + off) mod N_REQ for off < N_REQ; works for non power-of-two N_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_REQ_U) begin
            sum = sum - N_REQ_U;
        end
        return sum[ID_W-1:0];
    endfunction

    // Number of consecutive zero bits starting at bit 0; all-zero gives
    // DATA_WIDTH. Scanning from the MSB down leaves the lowest set bit last.
    function automatic logic [CNT_W-1:0] trailing_zeros(input logic [DATA_WIDTH-1:0] w);
        logic [CNT_W-1:0] n;
        n = CNT_W'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (w[i]) begin
                n = CNT_W'(i);
            end
        end
        return n;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ID_W-1:0] ptr;          // highest-priority requester this cycle

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic                  can_load;
    logic                  handoff;
    logic                  grant_any;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       next_ptr;
    logic [DATA_WIDTH-1:0] grant_word;
    logic [CNT_W-1:0]      grant_count;

    // The response register can take a new result when it is empty or is
    // being emptied this same cycle; this gives one word per cycle.
    assign can_load = !resp_valid || resp_ready;
    assign handoff  = resp_valid && resp_ready;

    // First set req_valid bit searching upward from ptr with wrap-around.
    // Suppressed during reset so nothing is accepted while reset is high.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (can_load && !reset) begin
            for (int unsigned k = 0; k < N_REQ_U; k++) begin
                if (!grant_any && req_valid[wrap_idx(ptr, k)]) begin
                    grant_any = 1'b1;
                    grant_idx = wrap_idx(ptr, k);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Only the granted lane is selected, so X/Z on the data of any other
    // requester never reaches the datapath.
    assign grant_word  = req_data[32'(grant_idx) * DW_U +: DATA_WIDTH];
    assign grant_count = trailing_zeros(grant_word);

    assign next_ptr = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // -----------------------------------------------------------------------
    // Response register, pointer and handoff counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_count <= '0;
            served_cnt <= '0;
        end else begin
            if (handoff) begin
                served_cnt <= served_cnt + 16'd1;
            end
            // A grant implies can_load, so loading here also covers the
            // simultaneous handoff-and-grant case without a bubble.
            if (grant_any) begin
                resp_valid <= 1'b1;
                resp_id    <= grant_idx;
                resp_data  <= grant_word;
                resp_count <= grant_count;
                ptr        <= next_ptr;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tz_rr_scheduler.sv
module tb_tz_rr_scheduler;

    localparam int DW  = 4;
    localparam int NR  = 4;
    localparam int IDW = $clog2(NR);
    localparam int CW  = $clog2(DW) + 1;
    localparam int SW  = NR + 1 + IDW + DW + CW + 16;
    localparam int SBW = IDW + DW + CW;

    // ---------------------------------------------------------------- clock/reset
    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [DW-1:0]     resp_data;
    logic [CW-1:0]     resp_count;
    logic [15:0]       served_cnt;

    always #5 clk = ~clk;

    tz_rr_scheduler #(.DATA_WIDTH(DW), .N_REQ(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_count (resp_count),
        .served_cnt (served_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------------------------------------------------------- reference model
    int m_ptr, m_id, m_data, m_count, m_served;
    bit m_valid;
    logic [SBW-1:0] exp_q[$];

    // Observed / expected snapshot of one cycle, filled by tick().
    logic [SW-1:0]  obs_snap, exp_snap;
    logic [NR-1:0]  o_ready;
    logic           o_valid;
    logic [IDW-1:0] o_id;
    logic [DW-1:0]  o_data;
    logic [CW-1:0]  o_count;
    logic [15:0]    o_served;

    function automatic int ref_tz(input int w);
        int c = 0;
        while (c < DW && ((w >> c) & 1) == 0) c++;
        return c;
    endfunction

    // Index the arbiter must pick this cycle, -1 for none.
    function automatic int ref_grant();
        if (reset || (m_valid && !resp_ready)) return -1;
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        m_ptr = 0; m_id = 0; m_data = 0; m_count = 0; m_served = 0; m_valid = 0;
        exp_q.delete();
    endfunction

    // ---------------------------------------------------------------- driver tasks
    // Sample at the falling edge, advance the model at the rising edge, and
    // return 1 time unit after it so the caller can drive the next inputs.
    task automatic tick();
        int g;
        logic [NR-1:0] er;
        logic [DW-1:0] w;
        @(negedge clk);
        g  = ref_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        exp_snap = {er, m_valid, IDW'(m_valid ? m_id : 0), DW'(m_valid ? m_data : 0),
                    CW'(m_valid ? m_count : 0), 16'(m_served)};
        o_ready = req_ready; o_valid = resp_valid; o_id = resp_id;
        o_data = resp_data; o_count = resp_count; o_served = served_cnt;
        obs_snap = {req_ready, resp_valid, resp_valid ? resp_id : {IDW{1'b0}},
                    resp_valid ? resp_data : {DW{1'b0}}, resp_valid ? resp_count : {CW{1'b0}},
                    served_cnt};
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (m_valid && resp_ready) m_served = (m_served + 1) % 65536;
            if (g >= 0) begin
                w       = req_data[g*DW +: DW];
                m_valid = 1;
                m_id    = g;
                m_data  = int'(w);
                m_count = ref_tz(int'(w));
                m_ptr   = (g + 1) % NR;
                exp_q.push_back({IDW'(g), w, CW'(m_count)});
            end else if (resp_ready) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; resp_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0; resp_ready = 1'b1;
        repeat (2) tick();
    endtask

    // ---------------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        logic [SBW-1:0] e;
        if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got id=%0d data=%b count=%0d, required no response",
                         resp_id, resp_data, resp_count);
            end else begin
                e = exp_q.pop_front();
                if ({resp_id, resp_data, resp_count} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard: got id/data/count %h, required %h",
                             {resp_id, resp_data, resp_count}, e);
                end
            end
        end
    end

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1; req_valid = '1; req_data = '0; resp_ready = 1'b1;
        repeat (2) begin
            tick();
            n_checks++;
            if (obs_snap !== exp_snap) begin
                n_fail++; $display("FAIL reset_snapshot: got %h required %h", obs_snap, exp_snap);
            end
        end
        n_checks++;
        if ({o_ready, o_valid, o_id, o_data, o_count, o_served} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got ready=%b valid=%b id=%0d data=%b count=%0d served=%0d, required all 0",
                     o_ready, o_valid, o_id, o_data, o_count, o_served);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int tbl[5] = '{4, 0, 1, 1, 0};
        logic [DW-1:0] words[5] = '{4'b0000, 4'b1111, 4'b0110, 4'b0010, 4'b0001};
        resp_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            req_data = 'x;
            if (i < 5) begin
                req_valid = 4'b0100;
                req_data[2*DW +: DW] = words[i];
            end else begin
                req_valid = '0;
            end
            tick();
            n_checks++;
            if (obs_snap !== exp_snap) begin
                n_fail++; $display("FAIL single_snapshot: got %h required %h", obs_snap, exp_snap);
            end
            if (i > 0) begin
                n_checks++;
                if (o_valid !== 1'b1 || o_id !== 2'd2 || o_count !== CW'(tbl[i-1])) begin
                    n_fail++;
                    $display("FAIL single_count[%0d]: got valid=%b id=%0d count=%0d, required valid=1 id=2 count=%0d",
                             i - 1, o_valid, o_id, o_count, tbl[i-1]);
                end
            end
        end
        tick();
        n_checks++;
        if (o_served !== 16'd5 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_served: got served=%0d valid=%b, required 5 and 0", o_served, o_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(1 << i);
        req_valid = '1; resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (obs_snap !== exp_snap || o_ready !== NR'(1 << (k % NR))) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got ready=%b snap=%h, required ready=%b snap=%h",
                         k, o_ready, obs_snap, NR'(1 << (k % NR)), exp_snap);
            end
            if (k > 0) begin
                n_checks++;
                if (o_id !== IDW'((k - 1) % NR) || o_count !== CW'((k - 1) % NR)) begin
                    n_fail++;
                    $display("FAIL rr_resp[%0d]: got id=%0d count=%0d, required %0d/%0d",
                             k, o_id, o_count, (k - 1) % NR, (k - 1) % NR);
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d0;
        do_reset();
        req_valid = '1; resp_ready = 1'b1;
        req_data = NR*DW'($urandom);
        d0 = req_data[0 +: DW];
        tick();
        resp_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            req_data = NR*DW'($urandom);
            tick();
            n_checks++;
            if (obs_snap !== exp_snap || o_ready !== '0 || o_valid !== 1'b1 || o_id !== '0 ||
                o_data !== d0 || o_count !== CW'(ref_tz(int'(d0)))) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ready=%b valid=%b id=%0d data=%b count=%0d, required 0000/1/0/%b/%0d",
                         h, o_ready, o_valid, o_id, o_data, o_count, d0, ref_tz(int'(d0)));
            end
        end
        resp_ready = 1'b1;
        tick();
        n_checks++;
        if (obs_snap !== exp_snap || o_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_release: got ready=%b, required 0010", o_ready);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_id !== 2'd1) begin
            n_fail++; $display("FAIL bp_no_bubble: got valid=%b id=%0d, required 1/1", o_valid, o_id);
        end
        drain();
    endtask

    task automatic test_pointer_skip();
        logic [NR-1:0] vseq[4] = '{4'b0010, 4'b1010, 4'b1010, 4'b0010};
        logic [NR-1:0] gseq[4] = '{4'b0010, 4'b1000, 4'b0010, 4'b0010};
        do_reset();
        resp_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            req_valid = vseq[s];
            req_data = NR*DW'($urandom);
            tick();
            n_checks++;
            if (obs_snap !== exp_snap || o_ready !== gseq[s]) begin
                n_fail++; $display("FAIL ptr_skip[%0d]: got ready=%b, required %b", s, o_ready, gseq[s]);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        req_valid = 4'b1000;
        req_data = '0;
        req_data[3*DW +: DW] = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_id !== 2'd3 || o_count !== CW'(3)) begin
            n_fail++; $display("FAIL mid_pending: got valid=%b id=%0d count=%0d, required 1/3/3", o_valid, o_id, o_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = '1; resp_ready = 1'b1;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(1 << i);
        tick();
        n_checks++;
        if (obs_snap !== exp_snap || o_valid !== 1'b0 || o_served !== 16'd0 || o_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_after_reset: got valid=%b served=%0d ready=%b, required 0/0/0001", o_valid, o_served, o_ready);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_id !== 2'd0 || o_count !== CW'(0)) begin
            n_fail++; $display("FAIL mid_first_grant: got valid=%b id=%0d count=%0d, required 1/0/0", o_valid, o_id, o_count);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid  = NR'($urandom_range(0, (1 << NR) - 1));
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) req_data[i*DW +: DW] = 'x;
                else req_data[i*DW +: DW] = DW'($urandom);
            end
            tick();
            n_checks++;
            if (obs_snap !== exp_snap) begin
                n_fail++; $display("FAIL random[%0d]: got %h required %h", c, obs_snap, exp_snap);
            end
        end
        drain();
    endtask

    task automatic test_wrap();
        bit found = 0;
        do_reset();
        req_valid = 4'b0001; resp_ready = 1'b1;
        for (int c = 0; c < 70000 && !found; c++) begin
            req_data = NR*DW'($urandom);
            tick();
            n_checks++;
            if (obs_snap !== exp_snap) begin
                n_fail++; $display("FAIL wrap_snapshot[%0d]: got %h required %h", c, obs_snap, exp_snap);
            end
            if (o_served === 16'hFFFF) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL wrap_reach: got served=%h, required FFFF within budget", o_served);
        end
        tick();
        n_checks++;
        if (o_served !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero: got served=%h, required 0000", o_served);
        end
        drain();
    endtask

    // ---------------------------------------------------------------- sequence + report
    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_pointer_skip();
        test_reset_mid();
        test_random();
        test_wrap();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL leftover_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
